// File: rtl/lfsr_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_ctrl_pkg
// Purpose  : Shared state encoding and constants for the LFSR sequencer.
// Revision : 1.0
// ============================================================================
package lfsr_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] LFSR_DEFAULT_SEED = 4'b1000;
    localparam int unsigned DIV_DEFAULT      = 25_000_000;

    // All-zero locks the LFSR up, so it is replaced by the default seed.
    function automatic logic [3:0] safe_seed(input logic [3:0] s);
        return (s == 4'b0000) ? LFSR_DEFAULT_SEED : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_ctrl_if
// Purpose  : Controller <-> 4-bit shift-register datapath connection.
// Revision : 1.0
// ============================================================================
interface lfsr_seq_ctrl_if;
    logic       shift_en;
    logic       ld;
    logic [3:0] ld_val;
    logic [3:0] lfsr_q;

    modport master (output shift_en, output ld, output ld_val, input lfsr_q);
    modport slave  (input shift_en, input ld, input ld_val, output lfsr_q);
endinterface
`default_nettype wire

// File: rtl/lfsr_seq_ctrl_tick_div.sv
`default_nettype none
// ============================================================================
// Module   : tick_div
// Purpose  : Loadable modulo-div_val counter with clear/enable, one-cycle tick.
// Revision : 1.0
// ============================================================================
module tick_div #(
    parameter int DIV_W = 26
) (
    input  wire logic             clk,
    input  wire logic             aset,
    input  wire logic             clr,
    input  wire logic             en,
    input  wire logic [DIV_W-1:0] div_val,
    output logic                  tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] cnt_cur;

    // A clear counts as phase 0 of the same cycle, so the clearing cycle is
    // itself the first divider cycle.
    always_comb begin
        cnt_cur = clr ? '0 : cnt_q;
        tick    = en && (cnt_cur == (div_val - DIV_W'(1)));
        cnt_d   = cnt_cur;
        if (en) begin
            cnt_d = tick ? '0 : (cnt_cur + DIV_W'(1));
        end
    end

    always_ff @(posedge clk or negedge aset) begin
        if (!aset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_ctrl
// Purpose  : Seed load, rate-divided run/step/burst shifting and wrap detect.
// Revision : 1.0
// ============================================================================
module lfsr_seq_ctrl
    import lfsr_seq_ctrl_pkg::*;
#(
    parameter int DIV_W  = 26,
    parameter int STEP_W = 8
) (
    input  wire logic              clk,
    input  wire logic              aset,
    input  wire logic              start,
    input  wire logic              stop,
    input  wire logic              step,
    input  wire logic              load,
    input  wire logic [3:0]        seed,
    input  wire logic [DIV_W-1:0]  div,
    input  wire logic [STEP_W-1:0] n_steps,
    lfsr_seq_ctrl_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   wrap,
    output logic [STEP_W-1:0]      step_cnt
);

    state_e              state_q, state_d, state_nxt;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   nsteps_q, nsteps_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d, step_cnt_nxt;
    logic                shift_en_q, shift_en_d;
    logic                ld_q, ld_d;
    logic [3:0]          ld_val_q, ld_val_d;
    logic [3:0]          ref_q, ref_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wrap_q, wrap_d;
    logic                wrap_pend_q;
    logic                step_pulse;
    logic                tick_clr;
    logic                tick_en;
    logic                tick;

    always_comb begin
        state_nxt    = state_q;
        div_d        = div_q;
        nsteps_d     = nsteps_q;
        step_cnt_nxt = step_cnt_q;
        step_pulse   = 1'b0;
        ld_d         = 1'b0;
        ld_val_d     = ld_val_q;
        ref_d        = ref_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        tick_clr     = 1'b0;
        tick_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    ld_d     = 1'b1;
                    ld_val_d = safe_seed(seed);
                    ref_d    = safe_seed(seed);
                end else if (start) begin
                    div_d        = (div == '0) ? DIV_W'(1) : div;
                    nsteps_d     = n_steps;
                    step_cnt_nxt = '0;
                    tick_clr     = 1'b1;
                    tick_en      = 1'b1;
                    busy_d       = 1'b1;
                    state_nxt    = ST_RUN;
                end else if (step) begin
                    step_pulse = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tick_en = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                done_d    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk     (clk),
        .aset    (aset),
        .clr     (tick_clr),
        .en      (tick_en),
        .div_val (div_d),
        .tick    (tick)
    );

    // busy stays high through the final shift of a burst; DONE follows it.
    always_comb begin
        shift_en_d = step_pulse | tick;
        step_cnt_d = tick ? (step_cnt_nxt + STEP_W'(1)) : step_cnt_nxt;
        state_d    = state_nxt;
        if (tick && (nsteps_d != '0) && (step_cnt_d == nsteps_d)) begin
            state_d = ST_DONE;
        end
        wrap_d = wrap_pend_q && (bus.lfsr_q == ref_q);
    end

    always_ff @(posedge clk or negedge aset) begin
        if (!aset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            nsteps_q    <= '0;
            step_cnt_q  <= '0;
            shift_en_q  <= 1'b0;
            ld_q        <= 1'b0;
            ld_val_q    <= LFSR_DEFAULT_SEED;
            ref_q       <= LFSR_DEFAULT_SEED;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            nsteps_q    <= nsteps_d;
            step_cnt_q  <= step_cnt_d;
            shift_en_q  <= shift_en_d;
            ld_q        <= ld_d;
            ld_val_q    <= ld_val_d;
            ref_q       <= ref_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
            wrap_pend_q <= shift_en_q;
        end
    end

    assign bus.shift_en = shift_en_q;
    assign bus.ld       = ld_q;
    assign bus.ld_val   = ld_val_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign wrap         = wrap_q;
    assign step_cnt     = step_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_seq_ctrl
// Purpose  : Scoreboard bench with a timeline-based reference model.
// Revision : 1.0
// ============================================================================
module tb_lfsr_seq_ctrl;

    localparam int DIV_W  = 26;
    localparam int STEP_W = 8;

    typedef struct packed {
        logic              shift_en;
        logic              ld;
        logic [3:0]        ld_val;
        logic              busy;
        logic              done;
        logic              wrap;
        logic [STEP_W-1:0] step_cnt;
    } exp_t;

    localparam exp_t RESET_EXP = {1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 8'd0};

    logic              clk = 1'b0;
    logic              aset;
    logic              start, stop, step, load;
    logic [3:0]        seed;
    logic [DIV_W-1:0]  div;
    logic [STEP_W-1:0] n_steps;
    logic              busy, done, wrap;
    logic [STEP_W-1:0] step_cnt;
    logic [3:0]        dp_q;

    int n_cmp = 0;
    int n_bad = 0;

    lfsr_seq_ctrl_if bus ();

    lfsr_seq_ctrl #(.DIV_W(DIV_W), .STEP_W(STEP_W)) dut (
        .clk      (clk),
        .aset     (aset),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .load     (load),
        .seed     (seed),
        .div      (div),
        .n_steps  (n_steps),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural datapath register fed back to the controller.
    always @(posedge clk or negedge aset) begin
        if (!aset)             dp_q <= 4'b1000;
        else if (bus.ld)       dp_q <= bus.ld_val;
        else if (bus.shift_en) dp_q <= {dp_q[3] ^ dp_q[2], dp_q[3:1]};
    end
    assign bus.lfsr_q = dp_q;

    exp_t dut_o;
    always_comb dut_o = {bus.shift_en, bus.ld, bus.ld_val, busy, done, wrap, step_cnt};

    task automatic check(input string name, input exp_t act, input exp_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got sh=%b ld=%b ldv=%h busy=%b done=%b wrap=%b cnt=%0d, want sh=%b ld=%b ldv=%h busy=%b done=%b wrap=%b cnt=%0d",
                     name, $time, act.shift_en, act.ld, act.ld_val, act.busy, act.done, act.wrap, act.step_cnt,
                     req.shift_en, req.ld, req.ld_val, req.busy, req.done, req.wrap, req.step_cnt);
        end
    endtask

    // Reference model: time-line view. A run begun at edge e0 with period dd
    // shifts at every edge t with (t - e0) mod dd == dd - 1.
    exp_t   sb[$];
    longint t, e0, dd;
    int     nn, cnt;
    bit     run, in_done;
    logic [3:0] m_q, m_ref, m_ldv;
    exp_t   prev1, prev2;

    always @(posedge clk or negedge aset) begin : model
        exp_t o;
        if (!aset) begin
            sb.delete();
            t = 0; e0 = 0; dd = 1; nn = 0; cnt = 0;
            run = 0; in_done = 0;
            m_q = 4'b1000; m_ref = 4'b1000; m_ldv = 4'b1000;
            prev1 = '0; prev2 = '0;
        end else begin
            o = '0;
            o.wrap = prev2.shift_en && (m_q == m_ref);
            if (prev1.ld)            m_q = prev1.ld_val;
            else if (prev1.shift_en) m_q = {m_q[3] ^ m_q[2], m_q[3:1]};
            if (in_done) begin
                in_done = 0;
                o.done  = 1'b1;
            end else if (run) begin
                if (stop) run = 0;
            end else if (load) begin
                o.ld  = 1'b1;
                m_ldv = (seed == 4'd0) ? 4'b1000 : seed;
                m_ref = m_ldv;
            end else if (start) begin
                run = 1; e0 = t; nn = int'(n_steps); cnt = 0;
                dd  = (div == '0) ? 1 : longint'(div);
            end else if (step) begin
                o.shift_en = 1'b1;
            end
            if (run && (((t - e0) % dd) == dd - 1)) begin
                o.shift_en = 1'b1;
                cnt = (cnt + 1) % 256;
                if (nn != 0 && cnt == nn) begin
                    run = 0; in_done = 1; o.busy = 1'b1;
                end
            end
            if (run) o.busy = 1'b1;
            o.ld_val   = m_ldv;
            o.step_cnt = 8'(cnt);
            sb.push_back(o);
            prev2 = prev1;
            prev1 = o;
            t++;
        end
    end

    always @(negedge clk) begin : monitor
        if (!aset) begin
            check("reset", dut_o, RESET_EXP);
        end else if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty @%0t: got no expectation, want one per cycle", $time);
        end else begin
            check("cycle", dut_o, sb.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(input bit l, input bit s, input bit p, input bit o,
                       input logic [3:0] sd, input int dv, input int ns);
        load = l; start = s; step = p; stop = o;
        seed = sd; div = DIV_W'(dv); n_steps = STEP_W'(ns);
        @(negedge clk);
        load = 0; start = 0; step = 0; stop = 0;
    endtask

    initial begin
        aset = 1'b0;
        {load, start, step, stop} = '0;
        seed = '0; div = '0; n_steps = '0;
        repeat (3) @(negedge clk);
        #2 aset = 1'b1;
        @(negedge clk);

        cmd(1, 0, 0, 0, 4'b0000, 0, 0);          // zero seed substitution
        idle(2);
        cmd(1, 0, 0, 0, 4'b1011, 0, 0);
        cmd(0, 1, 0, 0, 4'b0000, 4, 6);          // burst with two wraps
        idle(30);
        cmd(0, 1, 0, 0, 4'b0000, 0, 0);          // continuous, then stop on a tick
        idle(6);
        cmd(0, 0, 0, 1, 4'b0000, 0, 0);
        idle(3);
        cmd(1, 1, 1, 0, 4'b0110, 3, 2);          // only the load wins
        idle(3);
        cmd(0, 1, 0, 0, 4'b0000, 5, 0);
        idle(6);
        cmd(0, 1, 0, 0, 4'b0000, 2, 1);          // ignored in RUN
        idle(12);
        cmd(0, 0, 0, 1, 4'b0000, 0, 0);
        idle(2);
        cmd(1, 0, 0, 0, 4'b1011, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) begin        // single steps
            cmd(0, 0, 1, 0, 4'b0000, 0, 0);
            idle(3);
        end

        cmd(0, 1, 0, 0, 4'b0000, 8, 0);          // async reset before a tick
        idle(4);
        #1 aset = 1'b0;
        #1 check("async_reset", dut_o, RESET_EXP);
        repeat (3) @(negedge clk);
        #2 aset = 1'b1;
        @(negedge clk);
        idle(10);

        for (int i = 0; i < 500; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            load  = (r < 5);
            start = (r >= 5  && r < 12);
            step  = (r >= 12 && r < 20);
            stop  = (r >= 20 && r < 23);
            if (r >= 95) {load, start, step, stop} = 4'($urandom);
            seed    = 4'($urandom);
            div     = DIV_W'($urandom_range(0, 5));
            n_steps = STEP_W'($urandom_range(0, 6));
            @(negedge clk);
        end
        {load, start, step, stop} = '0;
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Sequencing controller for the 4-bit shift-register/LFSR datapath used on the lab boards. It loads the datapath seed and produces a programmable-rate shift-enable. It supports run, stop, single-step and N-step bursts. It flags when the datapath state returns to the loaded seed. It sits between the board push-buttons/switches (already debounced and pulsed upstream) and the datapath register's `ena`/load inputs.

## Interface
Parameters:
- `DIV_W`, 26, width of the rate divider.
- `STEP_W`, 8, width of the step counter and `n_steps`.

Ports:
- `clk` in 1, board clock.
- `aset` in 1, asynchronous active-low reset.
- `start` in 1, one-cycle pulse: begin RUN.
- `stop` in 1, one-cycle pulse: abort RUN.
- `step` in 1, one-cycle pulse: single shift while IDLE.
- `load` in 1, one-cycle pulse: load `seed` into datapath.
- `seed` in 4, seed value.
- `div` in DIV_W, clocks per shift; latched at `start`.
- `n_steps` in STEP_W, burst length; latched at `start`; 0 = run forever.
- `lfsr_q` in 4, current datapath state.
- `shift_en` out 1, datapath shift enable.
- `ld` out 1, datapath load strobe.
- `ld_val` out 4, datapath load value.
- `busy` out 1, high while in RUN.
- `done` out 1, one-cycle pulse when a burst completes.
- `wrap` out 1, one-cycle pulse when `lfsr_q` returns to the reference seed.
- `step_cnt` out STEP_W, shifts issued since last `start`.

## Operation
- All outputs are registered.
- Reset values: `shift_en`=0, `ld`=0, `ld_val`=4'b1000, reference seed `ref`=4'b1000, `busy`=0, `done`=0, `wrap`=0, `step_cnt`=0, state IDLE, divider=0.
- States: IDLE, RUN, DONE.
- IDLE: commands are accepted with priority `load` > `start` > `step`; lower-priority commands in the same cycle are dropped.
  - `load`: `ld`=1 for one cycle and `ld_val`=`seed`. If `seed`==0, substitute 4'b1000, because all-zero is lock-up. `ref` takes the same value.
  - `start`: latch `div` (0 is treated as 1) and `n_steps`, clear the divider and `step_cnt`, go to RUN.
  - `step`: `shift_en`=1 for exactly one cycle; `step_cnt` is unchanged.
- RUN:
  - The divider increments every cycle. When divider==div-1 it wraps to 0, `shift_en`=1 for the next cycle, and `step_cnt`++ (wrapping modulo 2^STEP_W).
  - If `n_steps`≠0 and the incremented `step_cnt`==`n_steps`, go to DONE.
  - `stop` → IDLE. A tick due in the same cycle is suppressed.
  - `load`, `start` and `step` are ignored in RUN.
- DONE: lasts one cycle, with `done`=1 and `busy`=0, then IDLE. Commands are ignored.
- Wrap detect:
  - When `shift_en` is high, set a pending flag.
  - The next cycle, compare the updated `lfsr_q` against `ref`. On a match, `wrap`=1 for one cycle.
  - Detection also runs on single steps.
- Reset mid-operation: all state and outputs return to the reset values immediately (asynchronous). Any pending wrap is discarded.

## Timing
- `start` sampled at edge E:
  - `busy`=1 from E+1.
  - First `shift_en` is high in cycle E+div.
  - Subsequent ticks every `div` cycles.
  - With `div`=1, `shift_en` is continuous.
- `load` at E: `ld` high in cycle E+1 only.
- `step` at E: `shift_en` high in cycle E+1 only.
- Datapath updates at the edge after `shift_en` is high, so `wrap` is high two cycles after the `shift_en` cycle.
- Burst end: the N-th `shift_en` cycle is followed by one cycle of `done`=1, `busy`=0, `shift_en`=0.
- `stop` at E: `busy`=0 and `shift_en`=0 from E+1.

## Structure
- Shared package holds:
  - the state encoding (IDLE/RUN/DONE);
  - the `LFSR_DEFAULT_SEED` constant, 4'b1000;
  - the `DIV_DEFAULT` constant, 25_000_000.
- One sub-module, `tick_div`: a loadable modulo-`div` counter with clear and enable, producing a single-cycle tick.
- The FSM, step counter and wrap detect stay in the top module.
- The bench includes a behavioural datapath: on `ld`, q<=`ld_val`; on `shift_en`, q<={q[3]^q[2], q[3:1]}. Its q feeds back to `lfsr_q`.

## Test plan
- Reset, then `load` with `seed`=0 → `ld` pulse with `ld_val`=4'b1000. All other outputs are at their reset values.
- `load` `seed`=4'b1011, then `start` with `div`=4, `n_steps`=6:
  - `shift_en` pulses every 4 cycles, first at E+4.
  - `wrap` fires after the 3rd and 6th shifts (sequence 1011→1101→0110→1011).
  - `done` appears one cycle after the 6th shift.
  - `step_cnt`=6.
- `start` with `div`=0, `n_steps`=0 → `shift_en` is continuous. `stop` on a tick cycle → that tick is suppressed and `busy` drops on the next cycle.
- Simultaneous `load`+`start`+`step` in IDLE → only `ld` is pulsed. `start` during RUN → ignored, and the divider phase is unchanged.
- IDLE `step` ×3 from seed 4'b1011 → three single `shift_en` pulses and one `wrap`; `step_cnt` stays 0.
- `aset` asserted mid-RUN, 2 cycles before a tick → no tick. All outputs are at their reset values immediately, and `ld_val`=4'b1000.
